// File: rtl/shadow_ram_host_port.sv
// shadow_ram_host_port: shadow RAM filled by the copy engine, then served to the host over pipelined Avalon-MM.
module shadow_ram_host_port #(
  parameter int NUM_WORDS     = 512,
  parameter int ADDR_BITS     = $clog2(NUM_WORDS),
  parameter bit HOST_WRITABLE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] copy_addr_i,
  input  logic [31:0]          copy_data_i,
  input  logic [3:0]           copy_byte_enable_i,
  input  logic                 copy_write_enable_i,
  input  logic                 copy_complete_i,
  input  logic [ADDR_BITS-1:0] host_addr_i,
  input  logic                 host_read_i,
  input  logic                 host_write_i,
  input  logic [31:0]          host_writedata_i,
  input  logic [3:0]           host_byteenable_i,
  input  logic [2:0]           host_burstcount_i,
  output logic                 host_waitrequest_o,
  output logic [31:0]          host_readdata_o,
  output logic                 host_readdatavalid_o,
  output logic                 ready_o
);
  typedef enum logic [1:0] {LOAD, IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic [ADDR_BITS-1:0] baddr_q, baddr_d;
  logic ready_q, ready_d;
  logic rd_v_q, rd_v_d;
  logic valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ram_q;
  logic [31:0] mem [NUM_WORDS];
  logic [2:0] len;
  logic acc_rd, acc_wr, issue, load, we;
  logic [ADDR_BITS-1:0] issue_addr, next_addr, waddr;
  logic [31:0] wdata;
  logic [3:0] wbe;
  always_comb begin
    load       = state_q == LOAD;
    len        = host_burstcount_i == 3'd0 ? 3'd1 : host_burstcount_i > 3'd4 ? 3'd4 : host_burstcount_i;
    acc_wr     = state_q == IDLE && host_write_i;
    acc_rd     = state_q == IDLE && host_read_i && !host_write_i;
    issue      = acc_rd || state_q == BURST;
    issue_addr = state_q == BURST ? baddr_q : host_addr_i;
    // explicit wrap keeps addressing modulo NUM_WORDS even for non power-of-two depths
    next_addr  = issue_addr == ADDR_BITS'(NUM_WORDS - 1) ? '0 : issue_addr + 1'b1;
    state_d    = load ? (copy_complete_i ? IDLE : LOAD)
               : state_q == BURST ? (rem_q == 2'd1 ? IDLE : BURST)
               : (acc_rd && len != 3'd1 ? BURST : IDLE);
    rem_d      = state_q == BURST ? rem_q - 2'd1 : acc_rd ? 2'(len - 3'd1) : rem_q;
    baddr_d    = issue ? next_addr : baddr_q;
    ready_d    = ready_q | (load & copy_complete_i);
    rd_v_d     = issue;
    valid_d    = rd_v_q;
    rdata_d    = rd_v_q ? ram_q : rdata_q;
    we         = load ? copy_write_enable_i : acc_wr && HOST_WRITABLE;
    waddr      = load ? copy_addr_i : host_addr_i;
    wdata      = load ? copy_data_i : host_writedata_i;
    wbe        = load ? copy_byte_enable_i : host_byteenable_i;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      rem_q   <= '0;
      baddr_q <= '0;
      ready_q <= 1'b0;
      rd_v_q  <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      baddr_q <= baddr_d;
      ready_q <= ready_d;
      rd_v_q  <= rd_v_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we && wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    ram_q <= mem[issue_addr];
  end
  assign host_waitrequest_o   = state_q != IDLE;
  assign host_readdata_o      = rdata_q;
  assign host_readdatavalid_o = valid_q;
  assign ready_o              = ready_q;
endmodule

// File: tb/tb_shadow_ram_host_port.sv
// tb_shadow_ram_host_port: directed checks of load stall, pipelined bursts, host writes and reset recovery.
module tb_shadow_ram_host_port;
  logic clk = 1'b0, reset = 1'b1;
  logic [8:0] copy_addr = '0, host_addr = '0;
  logic [31:0] copy_data = '0, host_wdata = '0;
  logic [3:0] copy_be = '0, host_be = '0;
  logic copy_we = 1'b0, copy_done = 1'b0, host_rd = 1'b0, host_wr = 1'b0;
  logic [2:0] host_bc = '0;
  logic wait0, wait1, v0, v1, rdy0, rdy1;
  logic [31:0] d0, d1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  shadow_ram_host_port #(.NUM_WORDS(512), .HOST_WRITABLE(1'b1)) u_dut (
    .clk(clk), .reset(reset), .copy_addr_i(copy_addr), .copy_data_i(copy_data),
    .copy_byte_enable_i(copy_be), .copy_write_enable_i(copy_we), .copy_complete_i(copy_done),
    .host_addr_i(host_addr), .host_read_i(host_rd), .host_write_i(host_wr),
    .host_writedata_i(host_wdata), .host_byteenable_i(host_be), .host_burstcount_i(host_bc),
    .host_waitrequest_o(wait0), .host_readdata_o(d0), .host_readdatavalid_o(v0), .ready_o(rdy0));
  shadow_ram_host_port #(.NUM_WORDS(512), .HOST_WRITABLE(1'b0)) u_ro (
    .clk(clk), .reset(reset), .copy_addr_i(copy_addr), .copy_data_i(copy_data),
    .copy_byte_enable_i(copy_be), .copy_write_enable_i(copy_we), .copy_complete_i(copy_done),
    .host_addr_i(host_addr), .host_read_i(host_rd), .host_write_i(host_wr),
    .host_writedata_i(host_wdata), .host_byteenable_i(host_be), .host_burstcount_i(host_bc),
    .host_waitrequest_o(wait1), .host_readdata_o(d1), .host_readdatavalid_o(v1), .ready_o(rdy1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (wait0 !== 1'b1 || wait1 !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b/%b want 1", wait0, wait1); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", v0); end
    checks++; if (d0 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", d0); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", rdy0); end
    reset = 1'b0;
  endtask

  task automatic test_load_stall();
    host_addr = 9'h005; host_bc = 3'd1; host_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (wait0 !== 1'b1) begin errors++; $display("FAIL load_wait[%0d]: got %b want 1", i, wait0); end
      checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL load_valid[%0d]: got %b want 0", i, v0); end
      checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL load_ready[%0d]: got %b want 0", i, rdy0); end
    end
    host_rd = 1'b0;
  endtask

  task automatic test_copy();
    for (int k = 0; k < 512; k++) begin
      copy_we = 1'b1; copy_addr = 9'(k); copy_data = {4{8'(k)}}; copy_be = 4'hF;
      copy_done = k == 511;
      tick();
    end
    copy_we = 1'b0; copy_done = 1'b0;
    checks++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin errors++; $display("FAIL copy_ready: got %b/%b want 1", rdy0, rdy1); end
    checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL copy_idle_wait: got %b want 0", wait0); end
  endtask

  task automatic test_copy_ignored();
    copy_we = 1'b1; copy_addr = 9'h010; copy_data = 32'hAAAAAAAA; copy_be = 4'hF; copy_done = 1'b1;
    tick();
    copy_we = 1'b0; copy_done = 1'b0;
    host_addr = 9'h010; host_bc = 3'd1; host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 32'h10101010) begin errors++; $display("FAIL copy_after_ready: got v=%b %h want v=1 10101010", v0, d0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL ready_sticky: got %b want 1", rdy0); end
    tick();
  endtask

  task automatic test_reads();
    int a_t [5];
    int bc_t [5];
    int l_t [5];
    logic [8:0] ea;
    logic exp_w, exp_v;
    int j;
    a_t = '{'h005, 'h1FE, 'h010, 'h010, 'h0FF};
    bc_t = '{1, 4, 0, 7, 2};
    l_t = '{1, 4, 1, 4, 2};
    for (int t = 0; t < 5; t++) begin
      host_addr = 9'(a_t[t]); host_bc = 3'(bc_t[t]); host_rd = 1'b1;
      tick();
      host_rd = 1'b0;
      for (int i = 1; i <= 7; i++) begin
        exp_w = i < l_t[t];
        exp_v = i >= 2 && i < 2 + l_t[t];
        checks++; if (wait0 !== exp_w) begin errors++; $display("FAIL rd%0d_wait[%0d]: got %b want %b", t, i, wait0, exp_w); end
        checks++; if (v0 !== exp_v) begin errors++; $display("FAIL rd%0d_valid[%0d]: got %b want %b", t, i, v0, exp_v); end
        if (i >= 2) begin
          j = i - 2 < l_t[t] ? i - 2 : l_t[t] - 1;
          ea = 9'(a_t[t] + j);
          checks++; if (d0 !== {4{ea[7:0]}}) begin errors++; $display("FAIL rd%0d_data[%0d]: got %h want %h", t, i, d0, {4{ea[7:0]}}); end
        end
        if (i < 7) tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    host_addr = 9'h080; host_bc = 3'd2; host_rd = 1'b1;
    tick();
    checks++; if (wait0 !== 1'b1) begin errors++; $display("FAIL b2b_wait: got %b want 1", wait0); end
    host_addr = 9'h090; host_bc = 3'd1;
    tick();
    checks++; if (wait0 !== 1'b0 || v0 !== 1'b1 || d0 !== 32'h80808080) begin errors++; $display("FAIL b2b_beat0: got w=%b v=%b %h want w=0 v=1 80808080", wait0, v0, d0); end
    tick();
    host_rd = 1'b0;
    checks++; if (v0 !== 1'b1 || d0 !== 32'h81818181) begin errors++; $display("FAIL b2b_beat1: got v=%b %h want v=1 81818181", v0, d0); end
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 32'h90909090) begin errors++; $display("FAIL b2b_beat2: got v=%b %h want v=1 90909090", v0, d0); end
    tick();
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %b want 0", v0); end
  endtask

  task automatic test_host_write();
    host_addr = 9'h020; host_wdata = 32'hDEADBEEF; host_be = 4'b0011; host_wr = 1'b1;
    tick();
    checks++; if (wait0 !== 1'b0 || wait1 !== 1'b0) begin errors++; $display("FAIL wr_wait: got %b/%b want 0", wait0, wait1); end
    host_wr = 1'b0; host_bc = 3'd1; host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 32'h2020BEEF) begin errors++; $display("FAIL wr_readback: got v=%b %h want v=1 2020BEEF", v0, d0); end
    checks++; if (v1 !== 1'b1 || d1 !== 32'h20202020) begin errors++; $display("FAIL wr_readonly: got v=%b %h want v=1 20202020", v1, d1); end
    host_addr = 9'h021; host_wdata = 32'h12345678; host_be = 4'hF; host_wr = 1'b1; host_rd = 1'b1; host_bc = 3'd1;
    tick();
    host_wr = 1'b0; host_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL rw_dropped[%0d]: got %b/%b want 0", i, v0, v1); end
      tick();
    end
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 32'h12345678) begin errors++; $display("FAIL rw_write: got v=%b %h want v=1 12345678", v0, d0); end
    checks++; if (d1 !== 32'h21212121) begin errors++; $display("FAIL rw_readonly: got %h want 21212121", d1); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    host_addr = 9'h040; host_bc = 3'd4; host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 32'h40404040) begin errors++; $display("FAIL mid_beat0: got v=%b %h want v=1 40404040", v0, d0); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b/%b want 0", v0, v1); end
    checks++; if (wait0 !== 1'b1) begin errors++; $display("FAIL mid_reset_wait: got %b want 1", wait0); end
    checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b/%b want 0", rdy0, rdy1); end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (v0 !== 1'b0 || wait0 !== 1'b1) begin errors++; $display("FAIL post_reset[%0d]: got v=%b w=%b want v=0 w=1", i, v0, wait0); end
    end
    copy_done = 1'b1;
    tick();
    copy_done = 1'b0;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reload_ready: got %b want 1", rdy0); end
    host_addr = 9'h033; host_bc = 3'd1; host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 32'h33333333) begin errors++; $display("FAIL reload_data: got v=%b %h want v=1 33333333", v0, d0); end
    checks++; if (v1 !== 1'b1 || d1 !== 32'h33333333) begin errors++; $display("FAIL reload_data_ro: got v=%b %h want v=1 33333333", v1, d1); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_stall();
    test_copy();
    test_copy_ignored();
    test_reads();
    test_back_to_back();
    test_host_write();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
